// File: rtl/if_id_buf_pkg.sv
// Shared IF/ID definitions: bus widths, reset level, buffer depth default.
// Imported by the IF/ID buffer, its interface and its tests.
package if_id_buf_pkg;

  localparam logic RstEnable = 1'b1;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 32;
  localparam logic [31:0] ZeroWord = 32'h0;
  localparam int IfIdDepth = 2;

  // Update priority inside the buffer, highest first
  typedef enum logic [1:0] {
    PriRst = 2'd0,
    PriFlush = 2'd1,
    PriHs = 2'd2
  } pri_e;

endpackage

// File: rtl/if_id_buf_if.sv
// Fetch/decode handshake bundle for the IF/ID buffer.
// IF_ID_BUF_PERF_EN adds the performance counter outputs.
interface if_id_buf_if
  import if_id_buf_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus,
  parameter int DEPTH = IfIdDepth
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic flush_i;
  logic if_valid_i;
  logic [ADDR_W-1:0] if_pc_i;
  logic [INST_W-1:0] if_inst_i;
  logic if_ready_o;
  logic id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic id_ready_i;
  logic [CW-1:0] count_o;
`ifdef IF_ID_BUF_PERF_EN
  logic [31:0] perf_full_o;
  logic [15:0] perf_flush_o;
`endif

  modport slave (
    input flush_i, if_valid_i, if_pc_i,
    input if_inst_i, id_ready_i,
    output if_ready_o, id_valid_o, id_pc_o,
    output id_inst_o, count_o
`ifdef IF_ID_BUF_PERF_EN
    , output perf_full_o, perf_flush_o
`endif
  );

  modport master (
    output flush_i, if_valid_i, if_pc_i,
    output if_inst_i, id_ready_i,
    input if_ready_o, id_valid_o, id_pc_o,
    input id_inst_o, count_o
`ifdef IF_ID_BUF_PERF_EN
    , input perf_full_o, perf_flush_o
`endif
  );

endinterface

// File: rtl/if_id_buf_byteswap.sv
// inst_byteswap: reverses byte order of a word (little-endian memory to
// decode order). Shared with the data-memory load path.
module inst_byteswap #(
  parameter int INST_W = 32
) (
  input logic [INST_W-1:0] inst_i,
  output logic [INST_W-1:0] inst_o
);

  localparam int NB = INST_W / 8;

  for (genvar k = 0; k < NB; k++) begin : g_byte
    assign inst_o[8*k +: 8] = inst_i[8*(NB-1-k) +: 8];
  end

endmodule

// File: rtl/if_id_buf.sv
// IF->ID circular buffer with valid/ready on both sides and flush.
// Define IF_ID_BUF_PERF_EN to compile in the stall/flush counters.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus,
  parameter int DEPTH = IfIdDepth,
  parameter bit BYTE_SWAP = 1'b1
) (
  input logic clk,
  input logic rst,
  if_id_buf_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [INST_W-1:0] swapped;
  logic [INST_W-1:0] wr_inst;
  logic ready;
  logic valid;
  logic push;
  logic pop;

  // ready looks only at registered count, never at id_ready_i
  assign ready = count < CW'(DEPTH);
  assign valid = count != '0;
  assign push = bus.if_valid_i && ready;
  assign pop = valid && bus.id_ready_i;

  inst_byteswap #(
    .INST_W(INST_W)
  ) u_swap (
    .inst_i(bus.if_inst_i),
    .inst_o(swapped)
  );

  assign wr_inst = BYTE_SWAP ? swapped : bus.if_inst_i;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10: count <= count + CW'(1);
        2'b01: count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stale contents are harmless: count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= bus.if_pc_i;
      inst_mem[wr_ptr] <= wr_inst;
    end
  end

  assign bus.if_ready_o = ready;
  assign bus.id_valid_o = valid;
  assign bus.id_pc_o = valid ? pc_mem[rd_ptr] : '0;
  assign bus.id_inst_o = valid ? inst_mem[rd_ptr] : '0;
  assign bus.count_o = count;

`ifdef IF_ID_BUF_PERF_EN
  logic [31:0] perf_full;
  logic [15:0] perf_flush;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      perf_full <= '0;
      perf_flush <= '0;
    end else begin
      if (bus.if_valid_i && !ready && perf_full != '1)
        perf_full <= perf_full + 32'd1;
      if (bus.flush_i && perf_flush != '1)
        perf_flush <= perf_flush + 16'd1;
    end
  end

  assign bus.perf_full_o = perf_full;
  assign bus.perf_flush_o = perf_flush;
`endif

endmodule
